// File: rtl/lcd_line_fetch_sched.sv
// lcd_line_fetch_sched: paced burst prefetch of RGB565 lines into ping-pong buffers.
// Define LCD_LINE_DOUBLE_EN for a half-height source with every line shown twice.
module lcd_line_fetch_sched #(
  parameter int H_ACTIVE    = 800,
  parameter int V_ACTIVE    = 480,
  parameter int BURST_LEN   = 32,
  parameter int ADDR_W      = 24,
  parameter int FB_BASE     = 0,
  parameter int LINE_STRIDE = 800
) (
  input  logic              PixelClk,
  input  logic              nRST,
  input  logic              de_in,
  input  logic              vsync_in,
  input  logic [10:0]       x_pos,
  input  logic [9:0]        y_pos,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_len,
  input  logic              mem_ack,
  input  logic [15:0]       mem_rdata,
  input  logic              mem_rvalid,
  output logic [23:0]       rgb,
  output logic              underrun,
  output logic              busy
);

  localparam int XW = $clog2(H_ACTIVE);
  localparam int BW = $clog2(BURST_LEN);
`ifdef LCD_LINE_DOUBLE_EN
  localparam int F_END = V_ACTIVE / 2;
`else
  localparam int F_END = V_ACTIVE;
`endif

  typedef enum logic [1:0] {IDLE, CHECK, REQ, DATA} state_t;

  state_t        state;
  logic [9:0]    f;
  logic [9:0]    d;
  logic [10:0]   w;
  logic [10:0]   w_nxt;
  logic [BW-1:0] bcnt;
  logic          abort_q;
  logic          vsync_q;
  logic          de_q;
  logic          frame_start;
  logic          line_done;
  logic          last_beat;
  logic          wr_en;
  logic          can_fetch;
  logic [10:0]   d_lim;
  logic [9:0]    ysrc;
  logic          bank;
  logic [XW-1:0] rd_idx;
  logic [15:0]   rd_word;
  logic [15:0]   lbuf [2][H_ACTIVE];

  function automatic logic [23:0] expand(input logic [15:0] p);
    return {p[15:11], p[15:13], p[10:5], p[10:9], p[4:0], p[4:2]};
  endfunction

  function automatic logic [ADDR_W-1:0] line_addr(
    input logic [9:0]  fl,
    input logic [10:0] wo
  );
    return ADDR_W'(FB_BASE)
         + ADDR_W'(LINE_STRIDE) * ADDR_W'(fl)
         + ADDR_W'(wo);
  endfunction

  assign mem_len     = 8'(BURST_LEN);
  assign busy        = (state != IDLE);
  assign frame_start = vsync_in & ~vsync_q;
  assign line_done   = de_q & ~de_in;
  assign w_nxt       = w + 11'd1;
  assign last_beat   = (state == DATA) & mem_rvalid
                     & (bcnt == BW'(BURST_LEN - 1));
  assign wr_en       = (state == DATA) & mem_rvalid
                     & ~abort_q & ~frame_start;

`ifdef LCD_LINE_DOUBLE_EN
  assign d_lim = 11'(d >> 1) + 11'd2;
  assign ysrc  = y_pos >> 1;
  assign bank  = y_pos[1];
`else
  assign d_lim = {1'b0, d} + 11'd2;
  assign ysrc  = y_pos;
  assign bank  = y_pos[0];
`endif

  assign can_fetch = ({1'b0, f} < d_lim);
  assign rd_idx    = (x_pos < 11'(H_ACTIVE)) ? x_pos[XW-1:0] : '0;
  assign rd_word   = lbuf[bank][rd_idx];

  always_ff @(posedge PixelClk or negedge nRST) begin
    if (!nRST) begin
      state    <= IDLE;
      f        <= '0;
      d        <= '0;
      w        <= '0;
      bcnt     <= '0;
      abort_q  <= 1'b0;
      vsync_q  <= 1'b0;
      de_q     <= 1'b0;
      mem_req  <= 1'b0;
      mem_addr <= '0;
    end else begin
      vsync_q <= vsync_in;
      de_q    <= de_in;
      if (line_done && d != 10'(V_ACTIVE))
        d <= d + 10'd1;
      unique case (state)
        IDLE: begin
          if (frame_start)
            state <= CHECK;
        end
        CHECK: begin
          if (!frame_start) begin
            if (f == 10'(F_END)) begin
              state <= IDLE;
            end else if (can_fetch) begin
              w        <= '0;
              mem_addr <= line_addr(f, 11'd0);
              mem_req  <= 1'b1;
              state    <= REQ;
            end
          end
        end
        REQ: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            bcnt    <= '0;
            state   <= DATA;
          end
        end
        DATA: begin
          if (mem_rvalid) begin
            w    <= w_nxt;
            bcnt <= bcnt + BW'(1);
          end
          if (last_beat) begin
            if (abort_q || frame_start) begin
              abort_q <= 1'b0;
              state   <= CHECK;
            end else if (w_nxt < 11'(H_ACTIVE)) begin
              mem_addr <= line_addr(f, w_nxt);
              mem_req  <= 1'b1;
              state    <= REQ;
            end else begin
              f     <= f + 10'd1;
              state <= CHECK;
            end
          end
        end
        default: state <= IDLE;
      endcase
      // a new frame lets the open burst drain, then refetches from line 0
      if (frame_start) begin
        d <= '0;
        f <= '0;
        if (state == REQ || (state == DATA && !last_beat))
          abort_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge PixelClk) begin
    if (wr_en)
      lbuf[f[0]][w[XW-1:0]] <= mem_rdata;
  end

  always_ff @(posedge PixelClk or negedge nRST) begin
    if (!nRST) begin
      rgb      <= '0;
      underrun <= 1'b0;
    end else begin
      if (!de_in) begin
        rgb <= '0;
      end else if (ysrc < f) begin
        rgb <= expand(rd_word);
      end else begin
        rgb      <= '0;
        underrun <= 1'b1;
      end
      if (frame_start)
        underrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_lcd_line_fetch_sched.sv
// tb_lcd_line_fetch_sched: directed bench with a burst memory model
// whose words equal their address (line 0 word 0 overridable).
module tb_lcd_line_fetch_sched;

  logic        PixelClk = 1'b0;
  logic        nRST = 1'b1;
  logic        de_in = 1'b0;
  logic        vsync_in = 1'b0;
  logic [10:0] x_pos = '0;
  logic [9:0]  y_pos = '0;
  logic        mem_req;
  logic [23:0] mem_addr;
  logic [7:0]  mem_len;
  logic        mem_ack = 1'b0;
  logic [15:0] mem_rdata = '0;
  logic        mem_rvalid = 1'b0;
  logic [23:0] rgb;
  logic        underrun;
  logic        busy;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic        ack_en = 1'b1;
  logic [15:0] ovr0 = '0;
  int          bursts = 0;
  logic [23:0] last_addr = '0;

  always #5 PixelClk = ~PixelClk;

  lcd_line_fetch_sched dut (
    .PixelClk   (PixelClk),
    .nRST       (nRST),
    .de_in      (de_in),
    .vsync_in   (vsync_in),
    .x_pos      (x_pos),
    .y_pos      (y_pos),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_len    (mem_len),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata),
    .mem_rvalid (mem_rvalid),
    .rgb        (rgb),
    .underrun   (underrun),
    .busy       (busy)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge PixelClk);
    #2;
  endtask

  task automatic vsync_pulse();
    vsync_in = 1'b1;
    repeat (3) tick();
    vsync_in = 1'b0;
    tick();
  endtask

  task automatic wait_req(input logic [23:0] addr, input int lim,
                          output bit ok);
    ok = 1'b0;
    for (int i = 0; i < lim && !ok; i++) begin
      tick();
      if (mem_req && mem_addr == addr)
        ok = 1'b1;
    end
  endtask

  task automatic pix(input logic [10:0] x, input logic [9:0] y,
                     input logic [23:0] exp, input string tag);
    x_pos = x;
    y_pos = y;
    de_in = 1'b1;
    tick();
    chk(tag, rgb, exp);
  endtask

  // 1-cycle ack, then BURST_LEN back-to-back beats
  initial begin : mem_model
    logic [23:0] a;
    forever begin
      @(posedge PixelClk);
      #1;
      if (mem_req && ack_en) begin
        mem_ack = 1'b1;
        a = mem_addr;
        bursts++;
        last_addr = mem_addr;
        @(posedge PixelClk);
        #1;
        mem_ack = 1'b0;
        for (int i = 0; i < 32; i++) begin
          mem_rvalid = 1'b1;
          mem_rdata = (a == 24'd0 && i == 0) ? ovr0 : 16'(a + 24'(i));
          @(posedge PixelClk);
          #1;
        end
        mem_rvalid = 1'b0;
      end
    end
  end

  initial begin : main
    bit ok;
    int k;
    #1 nRST = 1'b0;
    #2;
    chk("rst_req", mem_req, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_rgb", rgb, 0);
    chk("rst_ur", underrun, 0);
    chk("rst_busy", busy, 0);
    chk("mem_len", mem_len, 32);
    tick();
    nRST = 1'b1;
    repeat (20) tick();
    chk("idle_busy", busy, 0);
    chk("idle_req", mem_req, 0);

    // frame 1: two lines prefetched, then throttled
    vsync_pulse();
    wait_req(24'd800, 4000, ok);
    chk("l1b0_addr", ok, 1);
    repeat (2500) tick();
    chk("thr_bursts", bursts, 50);
    chk("thr_last", last_addr, 1568);
    chk("thr_req", mem_req, 0);
    chk("thr_busy", busy, 1);
    chk("no_ur", underrun, 0);
    pix(5, 1, 24'h006529, "px5_1");
    pix(31, 1, 24'h0065FF, "px31_1");
    pix(0, 0, 24'h000000, "px0_0");
    x_pos = 3;
    y_pos = 2;
    tick();
    chk("ur_rgb", rgb, 0);
    chk("ur_set", underrun, 1);
    de_in = 1'b0;
    tick();
    chk("de0_rgb", rgb, 0);
    repeat (1500) tick();
    chk("l2_bursts", bursts, 75);
    chk("l2_last", last_addr, 2368);
    chk("ur_sticky", underrun, 1);
    pix(5, 2, 24'h00CB29, "px5_2");
    pix(5, 1, 24'h006529, "px5_1b");
    de_in = 1'b0;
    repeat (1500) tick();

    // frame 2: white pixel at origin
    ovr0 = 16'hFFFF;
    vsync_pulse();
    chk("ur_clear", underrun, 0);
    repeat (2000) tick();
    pix(0, 0, 24'hFFFFFF, "px_ffff");
    pix(1, 0, 24'h000008, "px1_0");
    de_in = 1'b0;
    repeat (1500) tick();

    // frame 3: new frame arrives at beat 10 of line 1 burst 1
    ovr0 = 16'hF800;
    vsync_pulse();
    wait_req(24'd832, 4000, ok);
    chk("ab_req", ok, 1);
    k = 0;
    while (!mem_rvalid && k < 100) begin
      tick();
      k++;
    end
    chk("ab_data", mem_rvalid, 1);
    repeat (10) tick();
    vsync_in = 1'b1;
    k = 0;
    do begin
      tick();
      k++;
    end while (!mem_req && k < 200);
    vsync_in = 1'b0;
    chk("ab_req2", mem_req, 1);
    chk("ab_addr", mem_addr, 0);
    chk("ab_absorb", k >= 22, 1);
    repeat (2500) tick();
    pix(0, 0, 24'hFF0000, "px_f800");
    pix(40, 1, 24'h006942, "px40_1");
    de_in = 1'b0;
    repeat (1500) tick();

    // frame 4: memory never acks
    ack_en = 1'b0;
    vsync_pulse();
    repeat (50) tick();
    chk("fc_req", mem_req, 1);
    chk("fc_addr", mem_addr, 0);
    repeat (100) tick();
    chk("fc_req_hold", mem_req, 1);
    chk("fc_addr_hold", mem_addr, 0);
    x_pos = 0;
    y_pos = 0;
    de_in = 1'b1;
    tick();
    chk("fc_rgb", rgb, 0);
    chk("fc_ur", underrun, 1);
    de_in = 1'b0;
    repeat (20) tick();
    chk("fc_ur_sticky", underrun, 1);

    // reset in the middle of a burst
    ack_en = 1'b1;
    wait_req(24'd832, 4000, ok);
    chk("rb_req", ok, 1);
    repeat (5) tick();
    pix(5, 0, 24'h000029, "rb_pre_rgb");
    chk("rb_pre_busy", busy, 1);
    #1 nRST = 1'b0;
    #1;
    chk("rb_req0", mem_req, 0);
    chk("rb_addr0", mem_addr, 0);
    chk("rb_rgb0", rgb, 0);
    chk("rb_ur0", underrun, 0);
    chk("rb_busy0", busy, 0);
    de_in = 1'b0;
    repeat (3) tick();
    nRST = 1'b1;
    repeat (100) tick();
    chk("rb_idle_busy", busy, 0);
    chk("rb_idle_req", mem_req, 0);
    chk("rb_idle_rgb", rgb, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
